// File: rtl/nand_seq_pkg.sv
// Shared types and nand_master command codes for the NAND job sequencer.
package nand_seq_pkg;

  typedef enum logic [1:0] {
    JOB_INIT      = 2'd0,
    JOB_READ_ID   = 2'd1,
    JOB_STATUS    = 2'd2,
    JOB_READ_PAGE = 2'd3
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_EMIT,
    S_DONE,
    S_DRAIN
  } state_t;

  // Command codes as understood by nand_master's cmd_in port.
  localparam logic [7:0] M_NAND_RESET          = 8'h01;
  localparam logic [7:0] M_NAND_READ_ID        = 8'h03;
  localparam logic [7:0] M_NAND_READ           = 8'h06;
  localparam logic [7:0] MI_GET_STATUS         = 8'h08;
  localparam logic [7:0] MI_CHIP_ENABLE        = 8'h09;
  localparam logic [7:0] MI_RESET_INDEX        = 8'h0D;
  localparam logic [7:0] MI_GET_ID_BYTE        = 8'h0E;
  localparam logic [7:0] MI_GET_DATA_PAGE_BYTE = 8'h10;

endpackage

// File: rtl/nand_job_rom.sv
// Command table: each job is a short setup series, optionally followed by one
// fetch command that is repeated once per streamed byte.
module nand_job_rom
  import nand_seq_pkg::*;
(
  input  job_t       job_type,
  input  logic [1:0] step,
  output logic [7:0] cmd,
  output logic       is_fetch,
  output logic       is_repeat,
  output logic       is_last_setup
);

  always_comb begin
    cmd           = 8'h00;
    is_fetch      = 1'b0;
    is_repeat     = 1'b0;
    is_last_setup = 1'b0;
    case (job_type)
      JOB_INIT: begin
        if (step == 2'd0) begin
          cmd = MI_CHIP_ENABLE;
        end else begin
          cmd           = M_NAND_RESET;
          is_last_setup = 1'b1;
        end
      end
      JOB_READ_ID: begin
        if (step == 2'd0) begin
          cmd           = M_NAND_READ_ID;
          is_last_setup = 1'b1;
        end else begin
          cmd       = MI_GET_ID_BYTE;
          is_fetch  = 1'b1;
          is_repeat = 1'b1;
        end
      end
      JOB_STATUS: begin
        cmd       = MI_GET_STATUS;
        is_fetch  = 1'b1;
        is_repeat = 1'b1;
      end
      default: begin
        case (step)
          2'd0: cmd = MI_RESET_INDEX;
          2'd1: cmd = M_NAND_READ;
          2'd2: begin
            cmd           = MI_RESET_INDEX;
            is_last_setup = 1'b1;
          end
          default: begin
            cmd       = MI_GET_DATA_PAGE_BYTE;
            is_fetch  = 1'b1;
            is_repeat = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/nand_job_sequencer.sv
// Expands host jobs into nand_master command series and streams fetched bytes.
// out_valid/out_ready: a byte moves on a rising edge where both are high; out_data/out_last hold while stalled.
module nand_job_sequencer
  import nand_seq_pkg::*;
#(
  parameter int ID_BYTES = 5,
  parameter int LEN_W    = 13,
  parameter int TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_type,
  input  logic [LEN_W-1:0] job_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done,
  output logic             error,
  output logic [7:0]       m_cmd,
  output logic             m_activate,
  output logic [7:0]       m_data_in,
  input  logic             m_busy,
  input  logic [7:0]       m_data_out,
  output state_t           fsm_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state;
  job_t             type_q;
  job_t             job_in;
  logic [1:0]       step;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] total;
  logic [LEN_W-1:0] accept_total;
  logic [TW-1:0]    wait_cnt;
  logic [7:0]       cmd_hold;
  logic [7:0]       rom_cmd;
  logic             rom_fetch;
  logic             rom_repeat;
  logic             rom_last_setup;
  logic             last_rep;
  state_t           adv_state;
  logic [1:0]       adv_step;
  logic [LEN_W-1:0] adv_cnt;

  assign job_in = job_t'(job_type);

  nand_job_rom u_rom (
    .job_type      (type_q),
    .step          (step),
    .cmd           (rom_cmd),
    .is_fetch      (rom_fetch),
    .is_repeat     (rom_repeat),
    .is_last_setup (rom_last_setup)
  );

  // Number of fetch repetitions that follow the setup series.
  always_comb begin
    case (job_in)
      JOB_INIT:    accept_total = '0;
      JOB_READ_ID: accept_total = LEN_W'(ID_BYTES);
      JOB_STATUS:  accept_total = LEN_W'(1);
      default:     accept_total = job_len;
    endcase
  end

  assign last_rep = (cnt == total - LEN_W'(1));

  // Where to go once the current command has fully completed.
  always_comb begin
    adv_state = S_ISSUE;
    adv_step  = step;
    adv_cnt   = cnt;
    if (rom_repeat) begin
      if (last_rep) adv_state = S_DONE;
      else          adv_cnt   = cnt + LEN_W'(1);
    end else if (rom_last_setup && total == '0) begin
      adv_state = S_DONE;
    end else begin
      adv_step = step + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DRAIN;
      type_q    <= JOB_INIT;
      step      <= '0;
      cnt       <= '0;
      total     <= '0;
      wait_cnt  <= '0;
      cmd_hold  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_DRAIN: if (!m_busy) state <= S_IDLE;
        S_IDLE: begin
          if (job_valid) begin
            type_q <= job_in;
            total  <= accept_total;
            step   <= '0;
            cnt    <= '0;
            error  <= 1'b0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd_hold <= rom_cmd;
          state    <= S_SETTLE;
        end
        // The master raises busy a cycle after activate, so it is not looked at here.
        S_SETTLE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!m_busy) begin
            if (rom_fetch) begin
              out_data  <= m_data_out;
              out_valid <= 1'b1;
              out_last  <= last_rep;
              state     <= S_EMIT;
            end else begin
              state <= adv_state;
              step  <= adv_step;
              cnt   <= adv_cnt;
              done  <= (adv_state == S_DONE);
            end
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DRAIN;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= adv_state;
            step      <= adv_step;
            cnt       <= adv_cnt;
            done      <= (adv_state == S_DONE);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_DRAIN;
      endcase
    end
  end

  assign job_ready  = (state == S_IDLE);
  assign m_activate = (state == S_ISSUE);
  assign m_cmd      = (state == S_ISSUE) ? rom_cmd : cmd_hold;
  assign m_data_in  = 8'h00;
  assign fsm_state  = state;

endmodule

// File: tb/tb_nand_job_sequencer.sv
// Directed + randomized bench for nand_job_sequencer with a behavioural nand_master responder.
module tb_nand_job_sequencer;
  import nand_seq_pkg::*;

  localparam int LEN_W = 13;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_type;
  logic [LEN_W-1:0] job_len;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             done;
  logic             error;
  logic [7:0]       m_cmd;
  logic             m_activate;
  logic [7:0]       m_data_in;
  logic             m_busy;
  logic [7:0]       m_data_out;
  state_t           fsm_state;

  always #5 clk = ~clk;

  nand_job_sequencer #(.ID_BYTES(5), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_type(job_type), .job_len(job_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .error(error), .m_cmd(m_cmd), .m_activate(m_activate),
    .m_data_in(m_data_in), .m_busy(m_busy), .m_data_out(m_data_out),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // Master model state
  logic       busy_force;
  logic       stuck;
  logic       stick_read;
  int         busy_cnt;
  int         id_idx;
  int         pg_idx;
  logic [7:0] status_val;
  logic [7:0] id_tab[5];
  logic [7:0] page_mem[64];
  assign m_busy = busy_force || stuck || (busy_cnt != 0);

  // Monitor state
  int         cyc = 0;
  int         rdy_mode;
  logic [7:0] act_q[$];
  logic [7:0] din_q[$];
  logic [8:0] got_q[$];
  int         done_cnt;
  int         done_cyc;
  int         read_cyc;
  int         valid_seen;
  logic [8:0] held;
  bit         held_ok;

  // Expected values
  logic [7:0] exp_act[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // nand_master responder: reacts to activate, holds busy, serves bytes.
  initial begin
    busy_cnt = 0; id_idx = 0; pg_idx = 0; m_data_out = 8'h00; stuck = 1'b0;
    forever begin
      @(negedge clk);
      if (m_activate) begin
        busy_cnt = $urandom_range(0, 3);
        case (m_cmd)
          M_NAND_RESET:   busy_cnt = 20;
          M_NAND_READ_ID: id_idx = 0;
          MI_GET_ID_BYTE: begin m_data_out = id_tab[id_idx % 5]; id_idx++; end
          MI_GET_STATUS:  m_data_out = status_val;
          MI_RESET_INDEX: pg_idx = 0;
          M_NAND_READ:    if (stick_read) stuck = 1'b1;
          MI_GET_DATA_PAGE_BYTE: begin m_data_out = page_mem[pg_idx % 64]; pg_idx++; end
          default: ;
        endcase
      end else if (busy_cnt != 0) begin
        busy_cnt--;
      end
    end
  end

  // Output monitor and consumer: out_ready chosen here is what the DUT sees at the next edge.
  initial begin
    out_ready = 1'b0; held_ok = 0; done_cnt = 0; valid_seen = 0;
    forever begin
      @(negedge clk);
      if (m_activate) begin
        act_q.push_back(m_cmd);
        din_q.push_back(m_data_in);
        if (m_cmd == M_NAND_READ) read_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid) begin
        valid_seen++;
        if (held_ok) chk("stall_hold", {out_last, out_data}, held);
        if (out_ready) begin
          got_q.push_back({out_last, out_data});
          held_ok = 0;
        end else begin
          held = {out_last, out_data};
          held_ok = 1;
        end
      end else begin
        held_ok = 0;
      end
    end
  end

  task automatic build_exp(input int t, input int len, input bit tmo);
    exp_act.delete();
    exp_q.delete();
    if (tmo) begin
      exp_act.push_back(MI_RESET_INDEX);
      exp_act.push_back(M_NAND_READ);
      return;
    end
    case (t)
      0: begin exp_act.push_back(MI_CHIP_ENABLE); exp_act.push_back(M_NAND_RESET); end
      1: begin
        exp_act.push_back(M_NAND_READ_ID);
        for (int i = 0; i < 5; i++) begin
          exp_act.push_back(MI_GET_ID_BYTE);
          exp_q.push_back({1'b0, id_tab[i]});
        end
      end
      2: begin exp_act.push_back(MI_GET_STATUS); exp_q.push_back({1'b0, status_val}); end
      default: begin
        exp_act.push_back(MI_RESET_INDEX);
        exp_act.push_back(M_NAND_READ);
        exp_act.push_back(MI_RESET_INDEX);
        for (int i = 0; i < len; i++) begin
          exp_act.push_back(MI_GET_DATA_PAGE_BYTE);
          exp_q.push_back({1'b0, page_mem[i]});
        end
      end
    endcase
    if (exp_q.size() > 0) exp_q[exp_q.size()-1][8] = 1'b1;
  endtask

  task automatic start_job(input int t, input int len, input string tag);
    int n;
    act_q.delete(); din_q.delete(); got_q.delete();
    done_cnt = 0; valid_seen = 0;
    n = 0;
    while (!job_ready && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, job_ready, 1);
    job_valid = 1'b1;
    job_type  = t[1:0];
    job_len   = len[LEN_W-1:0];
    @(negedge clk);
    job_valid = 1'b0;
    chk({tag, "_first_act"}, m_activate, 1);
    chk({tag, "_err_clr"}, error, 0);
  endtask

  task automatic run_job(input int t, input int len, input string tag, input bit tmo);
    int n;
    logic [7:0] din_or;
    build_exp(t, len, tmo);
    start_job(t, len, tag);
    n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_nact"}, act_q.size(), exp_act.size());
    foreach (exp_act[i])
      if (i < act_q.size()) chk($sformatf("%s_cmd%0d", tag, i), act_q[i], exp_act[i]);
    din_or = 8'h00;
    foreach (din_q[i]) din_or = din_or | din_q[i];
    chk({tag, "_din"}, din_or, 0);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    if (exp_q.size() == 0) chk({tag, "_no_valid"}, valid_seen, 0);
  endtask

  initial begin
    int n;
    int t;
    int len;
    reset = 1'b1; busy_force = 1'b1; stick_read = 1'b0; job_valid = 1'b0;
    job_type = 2'd0; job_len = '0; rdy_mode = 0; status_val = 8'h00; read_cyc = 0; done_cyc = 0;
    id_tab[0] = 8'h2C; id_tab[1] = 8'hE5; id_tab[2] = 8'hFF; id_tab[3] = 8'h03; id_tab[4] = 8'h86;
    foreach (page_mem[i]) page_mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    chk("rst_job_ready", job_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_m_cmd", m_cmd, 0);
    chk("rst_m_activate", m_activate, 0);
    chk("rst_m_data_in", m_data_in, 0);

    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("ready_while_busy", job_ready, 0);
    end
    busy_force = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", job_ready, 1);

    rdy_mode = 0;
    run_job(0, 0, "init", 0);
    run_job(1, 0, "read_id", 0);
    rdy_mode = 1;
    run_job(3, 4, "page4", 0);
    rdy_mode = 0;
    run_job(3, 0, "page0", 0);

    for (int k = 0; k < 8; k++) begin
      t = $urandom_range(1, 3);
      len = $urandom_range(0, 40);
      rdy_mode = 2;
      status_val = 8'($urandom);
      foreach (page_mem[i]) page_mem[i] = 8'($urandom);
      run_job(t, len, $sformatf("rnd%0d", k), 0);
    end

    // Master stuck busy after the page read command: activate, settle, then TMO wait cycles.
    rdy_mode = 0;
    stick_read = 1'b1;
    run_job(3, 5, "tmo", 1);
    chk("tmo_latency", done_cyc - read_cyc, 2 + TMO);
    chk("tmo_error", error, 1);
    repeat (5) begin
      @(negedge clk);
      chk("tmo_drain_ready", job_ready, 0);
    end
    stick_read = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    chk("tmo_error_sticky", error, 1);
    run_job(0, 0, "after_tmo", 0);

    // Reset while a byte is being offered.
    rdy_mode = 3;
    start_job(3, 8, "rst_emit");
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("rst_emit_reached", out_valid, 1);
    done_cnt = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);

    rdy_mode = 0;
    status_val = 8'hE0;
    run_job(2, 0, "status_e0", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
